// File: rtl/bcd_scan_display.sv
// Three-digit multiplexed 7-segment driver for a BCD adder result.
// Holds a captured value and scans DIG0..DIG2 with leading-zero blanking.
module bcd_scan_display #(
  parameter int unsigned DIV = 4,
  parameter bit          LZB = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] s2,
  input  logic [3:0] s1,
  input  logic [3:0] s0,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       err,
  output logic       frame
);

  localparam logic [1:0] DIG0 = 2'd0;
  localparam logic [1:0] DIG1 = 2'd1;
  localparam logic [1:0] DIG2 = 2'd2;

  localparam logic [15:0] CMAX = 16'(DIV - 1);

  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  logic [3:0]  h2;
  logic [3:0]  h1;
  logic [3:0]  h0;
  logic [1:0]  sel;
  logic [1:0]  sel_nx;
  logic [15:0] cnt;
  logic [15:0] cnt_nx;
  logic        frame_nx;
  logic        wrap;
  logic        bad;
  logic [3:0]  dig;
  logic        blank;
  logic [6:0]  font;

  assign bad = (s2 > 4'd9) | (s1 > 4'd9) | (s0 > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h2  <= '0;
      h1  <= '0;
      h0  <= '0;
      err <= 1'b0;
    end else if (load) begin
      h2  <= s2;
      h1  <= s1;
      h0  <= s0;
      err <= bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel   <= DIG0;
      cnt   <= '0;
      frame <= 1'b0;
    end else begin
      sel   <= sel_nx;
      cnt   <= cnt_nx;
      frame <= frame_nx;
    end
  end

  // >= keeps the dwell bounded even if cnt were ever upset past CMAX
  always_comb begin
    wrap     = (cnt >= CMAX);
    sel_nx   = sel;
    cnt_nx   = cnt + 16'd1;
    frame_nx = 1'b0;
    case (sel)
      DIG0: begin
        if (wrap) begin
          sel_nx = DIG1;
          cnt_nx = '0;
        end
      end
      DIG1: begin
        if (wrap) begin
          sel_nx = DIG2;
          cnt_nx = '0;
        end
      end
      DIG2: begin
        if (wrap) begin
          sel_nx   = DIG0;
          cnt_nx   = '0;
          frame_nx = 1'b1;
        end
      end
      default: begin
        sel_nx = DIG0;
        cnt_nx = '0;
      end
    endcase
  end

  always_comb begin
    an    = 3'b110;
    dig   = h0;
    blank = 1'b0;
    unique case (1'b1)
      (sel == DIG1): begin
        an    = 3'b101;
        dig   = h1;
        blank = LZB && (h2 == 4'd0)
                    && (h1 == 4'd0);
      end
      (sel == DIG2): begin
        an    = 3'b011;
        dig   = h2;
        blank = LZB && (h2 == 4'd0);
      end
      default: begin
        an    = 3'b110;
        dig   = h0;
        blank = 1'b0;
      end
    endcase
  end

  always_comb begin
    font = SEG_E;
    case (dig)
      4'd0:    font = 7'h40;
      4'd1:    font = 7'h79;
      4'd2:    font = 7'h24;
      4'd3:    font = 7'h30;
      4'd4:    font = 7'h19;
      4'd5:    font = 7'h12;
      4'd6:    font = 7'h02;
      4'd7:    font = 7'h78;
      4'd8:    font = 7'h00;
      4'd9:    font = 7'h10;
      default: font = SEG_E;
    endcase
  end

  // blank only ever applies to a zero digit, so E is never hidden
  assign seg = blank ? SEG_OFF : font;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: three instances
// (DIV4/LZB1, DIV4/LZB0, DIV1/LZB1) against a cycle-count model.
module tb_bcd_scan_display;

  logic clk = 1'b0;
  logic rst_n;
  logic load;
  logic [3:0] s2, s1, s0;

  logic [2:0][6:0] seg;
  logic [2:0][2:0] an;
  logic [2:0]      err;
  logic [2:0]      frame;

  always #5 clk = ~clk;

  bcd_scan_display #(.DIV(4), .LZB(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .load(load),
    .s2(s2), .s1(s1), .s0(s0),
    .seg(seg[0]), .an(an[0]),
    .err(err[0]), .frame(frame[0])
  );

  bcd_scan_display #(.DIV(4), .LZB(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .load(load),
    .s2(s2), .s1(s1), .s0(s0),
    .seg(seg[1]), .an(an[1]),
    .err(err[1]), .frame(frame[1])
  );

  bcd_scan_display #(.DIV(1), .LZB(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .load(load),
    .s2(s2), .s1(s1), .s0(s0),
    .seg(seg[2]), .an(an[2]),
    .err(err[2]), .frame(frame[2])
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] an;
    logic       err;
    logic       frame;
  } obs_t;

  typedef obs_t [2:0] trio_t;

  trio_t sb[$];
  int compared = 0;
  int mismatched = 0;
  bit armed = 1'b0;

  // model: edges since reset plus the last captured value
  int         k;
  logic [3:0] m2, m1, m0;
  logic       merr;
  logic [6:0] font [16];

  function automatic obs_t model(int div, bit lzb);
    obs_t o;
    int p;
    logic [3:0] d;
    p = (k / div) % 3;
    d = (p == 0) ? m0 : ((p == 1) ? m1 : m2);
    o.an = 3'b111;
    o.an[p] = 1'b0;
    o.seg = font[d];
    if (lzb && ((p == 2 && m2 == 0) ||
                (p == 1 && m2 == 0 && m1 == 0)))
      o.seg = 7'h7F;
    o.err = merr;
    o.frame = (k > 0) && (k % (3 * div) == 0);
    return o;
  endfunction

  function automatic trio_t expect_all();
    trio_t t;
    t[0] = model(4, 1'b1);
    t[1] = model(4, 1'b0);
    t[2] = model(1, 1'b1);
    return t;
  endfunction

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    k = 0;
    m2 = 4'd0;
    m1 = 4'd0;
    m0 = 4'd0;
    merr = 1'b0;
  endtask

  task automatic step(bit rel, bit ld, logic [3:0] a2,
                      logic [3:0] a1, logic [3:0] a0);
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    load = ld;
    s2 = a2;
    s1 = a1;
    s0 = a0;
    if (rst_n) begin
      k++;
      if (ld) begin
        m2 = a2;
        m1 = a1;
        m0 = a0;
        merr = (a2 > 9) || (a1 > 9) || (a0 > 9);
      end
    end
    sb.push_back(expect_all());
    armed = 1'b1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  function automatic logic [3:0] rdig();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 4'd0;
    if (r == 9) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(1, 9));
  endfunction

  function automatic logic [3:0] rcarry();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return 4'd0;
    if (r < 9) return 4'd1;
    return 4'($urandom_range(10, 15));
  endfunction

  task automatic rand_steps(int n);
    for (int i = 0; i < n; i++)
      step(1'b0, ($urandom_range(0, 3) == 0),
           rcarry(), rdig(), rdig());
  endtask

  // asynchronous reset between edges, checked with no clock edge
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d rst an", i), 32'(an[i]), 32'b110);
      check($sformatf("u%0d rst seg", i), 32'(seg[i]), 32'h40);
      check($sformatf("u%0d rst err", i), 32'(err[i]), 32'd0);
      check($sformatf("u%0d rst frame", i), 32'(frame[i]), 32'd0);
    end
  endtask

  initial begin : monitor
    trio_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!armed) continue;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL sb_underflow: no expectation at %0t", $time);
        continue;
      end
      e = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("u%0d an", i), 32'(an[i]), 32'(e[i].an));
        check($sformatf("u%0d seg", i), 32'(seg[i]), 32'(e[i].seg));
        check($sformatf("u%0d err", i), 32'(err[i]), 32'(e[i].err));
        check($sformatf("u%0d frame", i), 32'(frame[i]),
              32'(e[i].frame));
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < 16; i++) font[i] = 7'h06;
    font[0] = 7'h40; font[1] = 7'h79; font[2] = 7'h24;
    font[3] = 7'h30; font[4] = 7'h19; font[5] = 7'h12;
    font[6] = 7'h02; font[7] = 7'h78; font[8] = 7'h00;
    font[9] = 7'h10;
    rst_n = 1'b0;
    load = 1'b0;
    s2 = 4'd0;
    s1 = 4'd0;
    s0 = 4'd0;
    model_clear();

    step(1'b0, 1'b1, 4'd1, 4'd5, 4'd5);
    step(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    idle(13);

    step(1'b0, 1'b1, 4'd1, 4'd2, 4'd3);
    idle(26);
    step(1'b0, 1'b1, 4'd0, 4'd0, 4'd7);
    idle(13);
    step(1'b0, 1'b1, 4'd0, 4'd0, 4'd0);
    idle(13);
    step(1'b0, 1'b1, 4'd0, 4'd1, 4'd12);
    idle(13);
    step(1'b0, 1'b1, 4'd0, 4'd1, 4'd2);
    idle(5);

    while (((k + 1) % 12) != 4) idle(1);
    step(1'b0, 1'b1, 4'd0, 4'd9, 4'd5);
    idle(14);

    rand_steps(400);

    while ((k % 12) != 10) rand_steps(1);
    do_reset();
    step(1'b0, 1'b1, 4'd1, 4'd8, 4'd8);
    step(1'b1, 1'b0, 4'd0, 4'd0, 4'd0);
    idle(14);

    rand_steps(300);
    do_reset();
    step(1'b1, 1'b1, 4'd1, 4'd9, 4'd9);
    rand_steps(60);

    @(posedge clk);
    #3;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL sb_drain: got %0d left expected 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
